count_sequencer: RTL and testbench

COUNT_SEQUENCER -- requirements
Module: count_sequencer

---
 rtl/count_seq_pkg.sv | 13 +
 rtl/count_seq_watchdog.sv | 37 +++
 rtl/count_sequencer.sv | 129 ++++++++++++
 tb/tb_count_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/count_seq_pkg.sv
// Shared types and constants for the count sequencer and its watchdog.
package count_seq_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/count_seq_watchdog.sv
// RUN-state cycle limiter, instantiated only when SEQ_TIMEOUT_EN is defined.
// expired is high during the TIMEOUT_CYCLES-th consecutive cycle of run.
module count_seq_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 300
) (
  input  logic clock,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned   CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (!run) begin
      count_d = '0;
    end else if (count_q != LAST) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = run && (count_q == LAST);

endmodule

// File: rtl/count_sequencer.sv
// Drives an up/down counter from preset to target, then pulses done.
// Define SEQ_TIMEOUT_EN to add a RUN-state cycle limit with a timeout flag.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int TIMEOUT_CYCLES = 300
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] preset,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] cnt_value,
  output logic [WIDTH-1:0] ctr_data,
  output logic             ctr_load,
  output logic             ctr_en,
  output logic             ctr_dir,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             dir_q, dir_d;
  logic             at_target;

  assign at_target = (cnt_value == target_q);

`ifdef SEQ_TIMEOUT_EN
  logic timed_out_q, timed_out_d;
  logic expired;

  count_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .clear  (clear),
    .run    (state_q == RUN),
    .expired(expired)
  );
`endif

  always_comb begin
    state_d  = state_q;
    preset_d = preset_q;
    target_d = target_q;
    dir_d    = dir_q;
`ifdef SEQ_TIMEOUT_EN
    timed_out_d = timed_out_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          preset_d = preset;
          target_d = target;
          dir_d    = (target > preset);
          state_d  = LOAD;
`ifdef SEQ_TIMEOUT_EN
          timed_out_d = 1'b0;
`endif
        end
      end
      LOAD: begin
        state_d = abort ? IDLE : RUN;
      end
      RUN: begin
        // abort wins over both match and timeout in the same cycle
        if (abort) begin
          state_d = IDLE;
        end else if (at_target) begin
          state_d = DONE;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (expired) begin
          state_d     = DONE;
          timed_out_d = 1'b1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q  <= IDLE;
      preset_q <= '0;
      target_q <= '0;
      dir_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      preset_q <= preset_d;
      target_q <= target_d;
      dir_q    <= dir_d;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (!clear) begin
      timed_out_q <= 1'b0;
    end else begin
      timed_out_q <= timed_out_d;
    end
  end

  assign timeout = (state_q == DONE) && timed_out_q;
`else
  assign timeout = 1'b0;
`endif

  // Enable drops the same cycle the counter reaches target, so it never overshoots.
  assign ctr_en   = (state_q == RUN) && !at_target;
  assign ctr_data = preset_q;
  assign ctr_load = (state_q == LOAD);
  assign ctr_dir  = dir_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer with a behavioural up/down counter.
// Expected results are pushed on start; a negedge monitor pops them on done.
module tb_count_sequencer;

`ifdef SEQ_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 1000000;
`endif

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] preset = '0;
  logic [7:0] target = '0;
  logic [7:0] cnt_value;
  logic [7:0] ctr_data;
  logic       ctr_load, ctr_en, ctr_dir, busy, done, timeout;

  always #5 clock = ~clock;

  count_sequencer #(
    .WIDTH(8),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clock    (clock),
    .clear    (clear),
    .start    (start),
    .abort    (abort),
    .preset   (preset),
    .target   (target),
    .cnt_value(cnt_value),
    .ctr_data (ctr_data),
    .ctr_load (ctr_load),
    .ctr_en   (ctr_en),
    .ctr_dir  (ctr_dir),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout)
  );

  // Downstream counter model
  logic [7:0] ctr_q = 8'h00;
  always @(posedge clock) begin
    if (ctr_load)    ctr_q <= ctr_data;
    else if (ctr_en) ctr_q <= ctr_dir ? ctr_q + 8'd1 : ctr_q - 8'd1;
  end
  assign cnt_value = ctr_q;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         acc;
    int         lat;
    int         en;
    logic [7:0] fin;
    logic       dir;
    logic       to;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per done pulse
  initial begin
    int   en_seen;
    exp_t e;
    en_seen = 0;
    forever begin
      @(negedge clock);
      if (!clear) begin
        en_seen = 0;
      end else begin
        if (ctr_load) en_seen = 0;
        if (ctr_en) en_seen++;
        if (done) begin
          if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_done: got done=1, required done=0");
          end else begin
            e = sb_q.pop_front();
            check("latency", cyc - e.acc + 1, e.lat);
            check("en_cycles", en_seen, e.en);
            check("final_cnt", {24'h0, cnt_value}, {24'h0, e.fin});
            check("dir_at_done", {31'h0, ctr_dir}, {31'h0, e.dir});
            check("timeout_flag", {31'h0, timeout}, {31'h0, e.to});
            $display("[TB] txn: latency=%0d en=%0d cnt=%02h dir=%0b timeout=%0b",
                     cyc - e.acc + 1, en_seen, cnt_value, ctr_dir, timeout);
          end
        end else if (timeout) begin
          check("timeout_without_done", {31'h0, timeout}, 32'h0);
        end
      end
    end
  end

  // Called at a negedge while IDLE; returns at the negedge of the first RUN cycle.
  task automatic issue(input logic [7:0] p, input logic [7:0] t);
    exp_t e;
    int   n;
    logic d;
    d = (t > p);
    n = d ? int'(t) - int'(p) : int'(p) - int'(t);
    e.acc = cyc + 1;
    e.dir = d;
    if (n >= TO) begin
      e.lat = TO + 2;
      e.en  = TO;
      e.fin = d ? 8'(int'(p) + TO) : 8'(int'(p) - TO);
      e.to  = 1'b1;
    end else begin
      e.lat = n + 3;
      e.en  = n;
      e.fin = t;
      e.to  = 1'b0;
    end
    sb_q.push_back(e);
    preset = p;
    target = t;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("load_pulse", {31'h0, ctr_load}, 32'h1);
    check("load_data", {24'h0, ctr_data}, {24'h0, p});
    check("load_dir", {31'h0, ctr_dir}, {31'h0, d});
    check("busy_in_load", {31'h0, busy}, 32'h1);
    @(negedge clock);
    check("load_once", {31'h0, ctr_load}, 32'h0);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge clock);
    tests++;
    if (busy) begin
      fails++;
      $display("[TB] FAIL idle_wait: busy still 1 after %0d cycles, required 0", budget);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {24'h0, ctr_data, ctr_load, ctr_en, ctr_dir, busy, done, timeout, 2'b00}, 32'h0);
  endtask

  initial begin
    // Reset
    clear = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset_outputs");
    clear = 1'b1;
    @(negedge clock);

    // Abort in IDLE has no effect
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_idle", {31'h0, busy}, 32'h0);

    // Increment, with a start while busy that must be ignored
    issue(8'h0B, 8'h10);
    preset = 8'h77;
    target = 8'h00;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("start_busy_ignored", {24'h0, ctr_data}, 32'h0B);
    check("dir_held", {31'h0, ctr_dir}, 32'h1);
    wait_idle(50);

    // Decrement
    @(negedge clock);
    issue(8'h20, 8'h1C);
    wait_idle(50);

    // Equal values, then a start in the DONE cycle that must be ignored
    @(negedge clock);
    issue(8'h55, 8'h55);
    @(negedge clock);
    check("done_cycle", {31'h0, done}, 32'h1);
    preset = 8'h40;
    target = 8'h41;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("start_done_ignored", {31'h0, busy}, 32'h0);

    // Abort in the third RUN cycle
    @(negedge clock);
    issue(8'h0B, 8'h10);
    @(negedge clock);
    @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    sb_q.delete();
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_en", {31'h0, ctr_en}, 32'h0);
    check("abort_cnt", {24'h0, cnt_value}, 32'h0E);
    repeat (5) @(negedge clock);
    check("abort_cnt_hold", {24'h0, cnt_value}, 32'h0E);

    // Reset mid-run, then a normal run
    issue(8'h0B, 8'h10);
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    sb_q.delete();
    check_all_zero("midrun_reset");
    clear = 1'b1;
    @(negedge clock);
    issue(8'h03, 8'h06);
    wait_idle(50);

    // No wrap-around: decrement 252 steps
    @(negedge clock);
    issue(8'hFE, 8'h02);
    wait_idle(300);

    // Timeout candidate (times out only with the limit compiled in)
    @(negedge clock);
    issue(8'h00, 8'h0A);
    wait_idle(50);

    repeat (3) @(negedge clock);
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL pending_txn: %0d expected done pulses never seen, required 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_time_limit: simulation still running, required finish");
    $fatal(1);
  end

endmodule
